arith_unit_mc: RTL

//  Parametrised, registered, multi-cycle successor to the combinational ALU arithmetic unit.

---
 rtl/arith_unit_mc.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/arith_unit_mc.sv
// Registered multi-cycle arithmetic unit: 1-cycle ADD/SUB/shift/rotate, WIDTH-cycle shift-add MUL.
// Define ARITH_FLAGS_EN to register {Z,N,C,V} with the result; otherwise o_flags is tied to zero.

module arith_unit_mc #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_mode,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [WIDTH-1:0] i_C,
  input  logic [WIDTH-1:0] i_D,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_out1,
  output logic [WIDTH-1:0] o_out2,
  output logic [3:0]       o_flags
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SCL, OP_SCR, OP_MUL
  } op_t;

  // Rotates go through a doubled operand so amount 0 needs no special case.
  function automatic logic [WIDTH-1:0] shift_rot(input op_t op, input logic [WIDTH-1:0] a,
                                                 input logic [SHW-1:0] amt);
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   r;
    dbl = {a, a};
    r   = a;
    case (op)
      OP_SLL:  r = a << amt;
      OP_SRL:  r = a >> amt;
      OP_SRA:  r = $signed(a) >>> amt;
      OP_SCL:  begin dbl = dbl << amt; r = dbl[2*WIDTH-1:WIDTH]; end
      OP_SCR:  begin dbl = dbl >> amt; r = dbl[WIDTH-1:0]; end
      default: r = a;
    endcase
    return r;
  endfunction

  op_t              op;
  logic             is_sub;
  logic [WIDTH-1:0] x1, y1, x2, y2, res1, res2;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out1_q, out1_d, out2_q, out2_d;
  logic [WIDTH-1:0] acc_q, acc_d, mpl_q, mpl_d, mcand_q, mcand_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_lo;

  assign op = op_t'(i_op);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    is_sub = (op == OP_SUB);
    x1     = i_A;
    y1     = i_mode ? i_C : i_B;
    x2     = i_mode ? i_B : i_C;
    y2     = i_D;
    res1   = shift_rot(op, i_A, i_B[SHW-1:0]);
    res2   = shift_rot(op, i_C, i_D[SHW-1:0]);
    if (op == OP_ADD || op == OP_SUB) begin
      res1 = is_sub ? x1 - y1 : x1 + y1;
      res2 = is_sub ? x2 - y2 : x2 + y2;
    end
  end

  // One partial product per cycle: {acc,mpl} shifts right, multiplier bits consumed LSB-first.
  assign mul_sum = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_lo  = {mul_sum[0], mpl_q[WIDTH-1:1]};

`ifdef ARITH_FLAGS_EN
  logic [3:0]     flags_q, flags_d, op_flags;
  logic [SHW-1:0] amt, sll_idx, srl_idx;
  logic           c_bit, v_bit;

  always_comb begin
    amt     = i_B[SHW-1:0];
    sll_idx = SHW'(0) - amt;
    srl_idx = amt - SHW'(1);
    c_bit   = 1'b0;
    v_bit   = 1'b0;
    case (op)
      OP_ADD: begin
        c_bit = (res1 < x1);
        v_bit = (x1[WIDTH-1] == y1[WIDTH-1]) && (res1[WIDTH-1] != x1[WIDTH-1]);
      end
      OP_SUB: begin
        c_bit = (x1 >= y1);
        v_bit = (x1[WIDTH-1] != y1[WIDTH-1]) && (res1[WIDTH-1] != x1[WIDTH-1]);
      end
      OP_SLL:         c_bit = (amt != '0) && i_A[sll_idx];
      OP_SRL, OP_SRA: c_bit = (amt != '0) && i_A[srl_idx];
      default:        c_bit = 1'b0;
    endcase
    op_flags = {res1 == '0, res1[WIDTH-1], c_bit, v_bit};
  end

  assign o_flags = flags_q;
`else
  assign o_flags = 4'b0000;
`endif

  always_comb begin
    state_d = state_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    acc_d   = acc_q;
    mpl_d   = mpl_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
`ifdef ARITH_FLAGS_EN
    flags_d = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (op == OP_MUL) begin
            mcand_d = i_mode ? i_C : i_A;
            mpl_d   = i_mode ? i_D : i_B;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            out1_d  = res1;
            out2_d  = res2;
`ifdef ARITH_FLAGS_EN
            flags_d = op_flags;
`endif
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        mpl_d = mul_lo;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          out2_d  = mul_sum[WIDTH:1];
          out1_d  = mul_lo;
`ifdef ARITH_FLAGS_EN
          flags_d = {({mul_sum[WIDTH:1], mul_lo} == '0), 3'b000};
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_out1  = out1_q;
  assign o_out2  = out2_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      out1_q  <= '0;
      out2_q  <= '0;
      acc_q   <= '0;
      mpl_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
`ifdef ARITH_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      acc_q   <= acc_d;
      mpl_q   <= mpl_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
`ifdef ARITH_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

endmodule
